// File: rtl/serial_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_fifo_ctrl
// Description : Bus-mapped serial port controller with RX and TX byte FIFOs,
//               sticky overrun/overflow flags, a threshold/idle interrupt and
//               a three-state transmit sequencer (IDLE/START/SETTLE).
//               Optional feature macro: SERIAL_FIFO_OVRCNT_EN adds an 8-bit
//               saturating dropped-RX-byte counter in STATUS[31:24].
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fifo_ctrl #(
    parameter int          RX_DEPTH_LOG2 = 4,     // legal range 1..7
    parameter int          TX_DEPTH_LOG2 = 4,     // legal range 1..7
    parameter logic [7:0]  RX_THRESH_RST = 8'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic        readEnable_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] dataSave_i,
    output logic [31:0] dataLoad_o,
    output logic        int_o,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o
);

    localparam int c_RX_DEPTH = 2 ** RX_DEPTH_LOG2;
    localparam int c_TX_DEPTH = 2 ** TX_DEPTH_LOG2;
    localparam int c_RX_CW    = RX_DEPTH_LOG2 + 1;
    localparam int c_TX_CW    = TX_DEPTH_LOG2 + 1;

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_START  = 2'd1;
    localparam logic [1:0] c_ST_SETTLE = 2'd2;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]               r_rx_mem [0:c_RX_DEPTH-1];
    logic [7:0]               r_tx_mem [0:c_TX_DEPTH-1];
    logic [RX_DEPTH_LOG2-1:0] r_rx_wr;
    logic [RX_DEPTH_LOG2-1:0] r_rx_rd;
    logic [c_RX_CW-1:0]       r_rx_cnt;
    logic [TX_DEPTH_LOG2-1:0] r_tx_wr;
    logic [TX_DEPTH_LOG2-1:0] r_tx_rd;
    logic [c_TX_CW-1:0]       r_tx_cnt;

    logic       r_rx_ovr;
    logic       r_tx_ovf;
    logic       r_rx_ie;
    logic       r_tx_ie;
    logic [7:0] r_rx_thresh;
    logic       r_int;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_txd_start;
    logic [7:0] r_txd_data;

    // ------------------------------------------------------------------
    // Decode and FIFO control
    // ------------------------------------------------------------------
    logic       w_bus_rd;
    logic       w_bus_wr;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_rx_pop;
    logic       w_rx_push;
    logic       w_rx_drop;
    logic       w_tx_pop;
    logic       w_tx_push;
    logic       w_tx_drop;
    logic       w_tx_idle;
    logic       w_stat_rd;
    logic       w_ctrl_wr;
    logic [7:0] w_rx_cnt8;
    logic [7:0] w_tx_cnt8;
    logic [7:0] w_ovr_field;
    logic [31:0] w_status;
    logic       w_int_cond;
    logic       w_unused_bits;

    assign w_bus_rd   = enable_i &  readEnable_i;
    assign w_bus_wr   = enable_i & ~readEnable_i;

    // Count MSB set means the count equals the depth
    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = r_rx_cnt[RX_DEPTH_LOG2];
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = r_tx_cnt[TX_DEPTH_LOG2];

    assign w_rx_pop   = w_bus_rd && (reg_i == c_REG_DATA) && !w_rx_empty;
    // A pop in the same cycle frees the slot the incoming byte needs
    assign w_rx_push  = rxdReady_i && (!w_rx_full || w_rx_pop);
    assign w_rx_drop  = rxdReady_i &&  w_rx_full && !w_rx_pop;

    assign w_tx_push  = w_bus_wr && (reg_i == c_REG_DATA) && (!w_tx_full || w_tx_pop);
    assign w_tx_drop  = w_bus_wr && (reg_i == c_REG_DATA) &&  w_tx_full && !w_tx_pop;

    assign w_stat_rd  = w_bus_rd && (reg_i == c_REG_STATUS);
    assign w_ctrl_wr  = w_bus_wr && (reg_i == c_REG_CTRL);

    assign w_tx_idle  = w_tx_empty && (r_state == c_ST_IDLE) && !txdBusy_i;

    assign w_rx_cnt8  = 8'(r_rx_cnt);
    assign w_tx_cnt8  = 8'(r_tx_cnt);

    // Upper write-data bits have no destination in any register
    assign w_unused_bits = ^dataSave_i[31:16];

    // ------------------------------------------------------------------
    // Optional dropped-byte counter
    // ------------------------------------------------------------------
`ifdef SERIAL_FIFO_OVRCNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating count of dropped RX bytes; a drop coinciding with the clearing read still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovr_cnt <= 8'h00;
        end else if (w_stat_rd) begin
            r_ovr_cnt <= w_rx_drop ? 8'h01 : 8'h00;
        end else if (w_rx_drop && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'h01;
        end
    end

    assign w_ovr_field = r_ovr_cnt;
`else
    assign w_ovr_field = 8'h00;
`endif

    assign w_status = {w_ovr_field, w_tx_cnt8, w_rx_cnt8, 3'b000,
                       w_tx_idle, r_tx_ovf, r_rx_ovr, !w_tx_full, !w_rx_empty};

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    // RX data array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr] <= rxdData_i;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + RX_DEPTH_LOG2'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + RX_DEPTH_LOG2'(1);
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt + c_RX_CW'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_cnt <= r_rx_cnt - c_RX_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    // TX data array
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr] <= dataSave_i[7:0];
        end
    end

    // TX pointers and occupancy; bus push and sequencer pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + TX_DEPTH_LOG2'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd <= r_tx_rd + TX_DEPTH_LOG2'(1);
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt + c_TX_CW'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_cnt <= r_tx_cnt - c_TX_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and control register
    // ------------------------------------------------------------------
    // Overrun/overflow flags: the event beats the clearing STATUS read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ovr <= 1'b0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_rx_drop) begin
                r_rx_ovr <= 1'b1;
            end else if (w_stat_rd) begin
                r_rx_ovr <= 1'b0;
            end
            if (w_tx_drop) begin
                r_tx_ovf <= 1'b1;
            end else if (w_stat_rd) begin
                r_tx_ovf <= 1'b0;
            end
        end
    end

    // CTRL register: interrupt enables and RX threshold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ie     <= 1'b1;
            r_tx_ie     <= 1'b0;
            r_rx_thresh <= RX_THRESH_RST;
        end else if (w_ctrl_wr) begin
            r_rx_ie     <= dataSave_i[0];
            r_tx_ie     <= dataSave_i[1];
            r_rx_thresh <= dataSave_i[15:8];
        end
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    // A zero threshold disables the RX level interrupt entirely
    assign w_int_cond = (r_rx_ie && (w_rx_cnt8 >= r_rx_thresh) && (r_rx_thresh != 8'h00))
                     || (r_tx_ie && w_tx_idle);

    // Registered interrupt request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int <= 1'b0;
        end else begin
            r_int <= w_int_cond;
        end
    end

    // ------------------------------------------------------------------
    // TX sequencer
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; busy is only consulted while idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_tx_empty && !txdBusy_i) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START:  w_state_nxt = c_ST_SETTLE;
            c_ST_SETTLE: w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode: the head is popped on the edge that enters START
    always_comb begin
        w_tx_pop = 1'b0;
        if ((r_state == c_ST_IDLE) && !w_tx_empty && !txdBusy_i) begin
            w_tx_pop = 1'b1;
        end
    end

    // Strobe and data registers: strobe is high exactly while in START
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd_start <= 1'b0;
            r_txd_data  <= 8'h00;
        end else begin
            r_txd_start <= w_tx_pop;
            if (w_tx_pop) begin
                r_txd_data <= r_tx_mem[r_tx_rd];
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus read mux
    // ------------------------------------------------------------------
    // Combinational read data, zero unless a read is in progress
    always_comb begin
        dataLoad_o = 32'h0000_0000;
        if (w_bus_rd) begin
            case (reg_i)
                c_REG_DATA: begin
                    if (!w_rx_empty) begin
                        dataLoad_o = {24'h00_0000, r_rx_mem[r_rx_rd]};
                    end
                end
                c_REG_STATUS: dataLoad_o = w_status;
                c_REG_CTRL:   dataLoad_o = {16'h0000, r_rx_thresh, 6'b000000, r_tx_ie, r_rx_ie};
                default:      dataLoad_o = 32'h0000_0000;
            endcase
        end
    end

    assign int_o      = r_int;
    assign txdStart_o = r_txd_start;
    assign txdData_o  = r_txd_data;

endmodule
`default_nettype wire

// File: tb/tb_serial_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_fifo_ctrl
// Description : Directed self-checking bench for serial_fifo_ctrl.
//               Inputs change on the falling edge; outputs are sampled on the
//               falling edge (registered) or 1 ns after driving (read data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_fifo_ctrl;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic        readEnable_i;
    logic [1:0]  reg_i;
    logic [31:0] dataSave_i;
    logic [31:0] dataLoad_o;
    logic        int_o;
    logic        rxdReady_i;
    logic [7:0]  rxdData_i;
    logic        txdBusy_i;
    logic        txdStart_o;
    logic [7:0]  txdData_o;

    int checks;
    int errors;

    serial_fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .readEnable_i (readEnable_i),
        .reg_i        (reg_i),
        .dataSave_i   (dataSave_i),
        .dataLoad_o   (dataLoad_o),
        .int_o        (int_o),
        .rxdReady_i   (rxdReady_i),
        .rxdData_i    (rxdData_i),
        .txdBusy_i    (txdBusy_i),
        .txdStart_o   (txdStart_o),
        .txdData_o    (txdData_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start just after a falling edge and end on the next one
    task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
        enable_i = 1'b1; readEnable_i = 1'b1; reg_i = r;
        #1 d = dataLoad_o;
        @(negedge clk);
        enable_i = 1'b0; readEnable_i = 1'b0; reg_i = 2'd0;
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] v);
        enable_i = 1'b1; readEnable_i = 1'b0; reg_i = r; dataSave_i = v;
        @(negedge clk);
        enable_i = 1'b0; reg_i = 2'd0; dataSave_i = 32'h0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rxdReady_i = 1'b1; rxdData_i = b;
        @(negedge clk);
        rxdReady_i = 1'b0; rxdData_i = 8'h00;
    endtask

    logic [31:0] rd;
    int          strobes;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; enable_i = 1'b0; readEnable_i = 1'b0; reg_i = 2'd0;
        dataSave_i = 32'h0; rxdReady_i = 1'b0; rxdData_i = 8'h00; txdBusy_i = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_txdStart", {31'h0, txdStart_o}, 32'h0);
        check("rst_txdData",  {24'h0, txdData_o},  32'h0);
        check("rst_int",      {31'h0, int_o},      32'h0);
        rst = 1'b0;
        bus_read(2'd1, rd); check("rst_status", rd, 32'h0000_0012);
        bus_read(2'd2, rd); check("rst_ctrl",   rd, 32'h0000_0101);
        bus_read(2'd0, rd); check("empty_data", rd, 32'h0);
        bus_read(2'd3, rd); check("reserved_rd", rd, 32'h0);
        readEnable_i = 1'b0;
        check("idle_dataLoad", dataLoad_o, 32'h0);

        // Two received bytes read back in order
        rx_push(8'h41);
        rx_push(8'h42);
        bus_read(2'd0, rd); check("rx_first",  rd, 32'h0000_0041);
        bus_read(2'd0, rd); check("rx_second", rd, 32'h0000_0042);
        bus_read(2'd1, rd); check("rx_drained_status", rd, 32'h0000_0012);

        // Overrun: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) rx_push(8'h20 + 8'(i));
        bus_read(2'd1, rd);
`ifdef SERIAL_FIFO_OVRCNT_EN
        check("ovr_status1", rd, 32'h0100_1017);
`else
        check("ovr_status1", rd, 32'h0000_1017);
`endif
        bus_read(2'd1, rd); check("ovr_status2", rd, 32'h0000_1013);

        // Full FIFO: push and pop in the same cycle
        enable_i = 1'b1; readEnable_i = 1'b1; reg_i = 2'd0;
        rxdReady_i = 1'b1; rxdData_i = 8'hEE;
        #1 rd = dataLoad_o;
        @(negedge clk);
        enable_i = 1'b0; readEnable_i = 1'b0; rxdReady_i = 1'b0;
        check("full_pushpop_data", rd, 32'h0000_0020);
        bus_read(2'd1, rd); check("full_pushpop_status", rd, 32'h0000_1013);
        for (int i = 1; i < 16; i++) begin
            bus_read(2'd0, rd); check("drain_byte", rd, 32'h20 + 32'(i));
        end
        bus_read(2'd0, rd); check("drain_last_new", rd, 32'h0000_00EE);
        bus_read(2'd1, rd); check("drain_status", rd, 32'h0000_0012);

        // Threshold interrupt
        bus_write(2'd2, 32'h0000_0301);
        @(negedge clk);
        check("int_thr_empty", {31'h0, int_o}, 32'h0);
        rx_push(8'h01);
        rx_push(8'h02);
        @(negedge clk);
        check("int_two_bytes", {31'h0, int_o}, 32'h0);
        rx_push(8'h03);
        check("int_third_same", {31'h0, int_o}, 32'h0);
        @(negedge clk);
        check("int_third_next", {31'h0, int_o}, 32'h1);
        bus_read(2'd0, rd); check("int_pop_data", rd, 32'h0000_0001);
        check("int_pop_same", {31'h0, int_o}, 32'h1);
        @(negedge clk);
        check("int_pop_next", {31'h0, int_o}, 32'h0);
        bus_read(2'd0, rd); bus_read(2'd0, rd);
        check("int_drain", rd, 32'h0000_0003);

        // Transmit with busy hold-off
        bus_write(2'd0, 32'h0000_0055);
        bus_write(2'd0, 32'h0000_00AA);
        check("tx1_strobe", {31'h0, txdStart_o}, 32'h1);
        check("tx1_data",   {24'h0, txdData_o},  32'h55);
        txdBusy_i = 1'b1;
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txdStart_o) strobes++;
        end
        check("tx1_no_strobe_busy", 32'(strobes), 32'h0);
        check("tx1_data_hold", {24'h0, txdData_o}, 32'h55);
        bus_read(2'd1, rd); check("tx1_status", rd, 32'h0001_0002);
        txdBusy_i = 1'b0;
        @(negedge clk);
        check("tx2_strobe", {31'h0, txdStart_o}, 32'h1);
        check("tx2_data",   {24'h0, txdData_o},  32'hAA);
        txdBusy_i = 1'b1;
        @(negedge clk);
        check("tx2_single", {31'h0, txdStart_o}, 32'h0);
        strobes = 0;
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            if (txdStart_o) strobes++;
        end
        check("tx2_no_strobe_busy", 32'(strobes), 32'h0);
        txdBusy_i = 1'b0;
        repeat (3) @(negedge clk);
        check("tx_done_start", {31'h0, txdStart_o}, 32'h0);
        bus_read(2'd1, rd); check("tx_done_status", rd, 32'h0000_0012);

        // TX overflow, then reset during START
        txdBusy_i = 1'b1;
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h60 + 32'(i));
        bus_read(2'd1, rd); check("txovf_status", rd, 32'h0010_0008);
        txdBusy_i = 1'b0;
        @(negedge clk);
        check("rstst_strobe", {31'h0, txdStart_o}, 32'h1);
        check("rstst_data",   {24'h0, txdData_o},  32'h60);
        rst = 1'b1;
        @(negedge clk);
        check("rstst_start_after", {31'h0, txdStart_o}, 32'h0);
        check("rstst_data_after",  {24'h0, txdData_o},  32'h0);
        check("rstst_int_after",   {31'h0, int_o},      32'h0);
        rst = 1'b0;
        bus_read(2'd1, rd); check("rstst_status", rd, 32'h0000_0012);
        bus_read(2'd2, rd); check("rstst_ctrl",   rd, 32'h0000_0101);
        check("rstst_start_idle", {31'h0, txdStart_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
